// File: rtl/mem_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_stage : MIPS32 memory-access stage (ready-handshaked data bus, load
// align/extend, store byte enables, registered writeback). Rev 1.0
// Optional: MEM_ALIGN_CHECK_EN traps misaligned half/word accesses in IDLE.
// ----------------------------------------------------------------------------
module mem_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  wreg_addr_i,
  input  logic        reg_write_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_reg_write_o,
  output logic [4:0]  wb_reg_addr_o,
  output logic [31:0] wb_data_o,
  output logic        exc_o,
  output logic [1:0]  exc_code_o,
  output logic [31:0] badaddr_o
);

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        we_q, sign_q, regwr_q;
  logic [1:0]  size_q;
  logic [4:0]  wreg_q;
  logic [7:0]  cnt;

  logic        mem_op, misalign, timeout;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, load_data, byte_sh, half_sh;

  assign mem_op  = valid_i & (mem_rd_i | mem_wr_i);
  assign timeout = (state == BUS) && (cnt == WAIT_LIM);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = ((mem_size_i == 2'b01) & addr_i[0]) |
                    (mem_size_i[1] & (|addr_i[1:0]));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wdata_i;
    case (mem_size_i)
      2'b00: begin
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_new    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata_i[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = wdata_i;
      end
    endcase
  end

  always_comb begin
    byte_sh   = dmem_rdata_i >> {addr_q[1:0], 3'b000};
    half_sh   = dmem_rdata_i >> {addr_q[1], 4'b0000};
    load_data = dmem_rdata_i;
    case (size_q)
      2'b00:   load_data = {{24{sign_q & byte_sh[7]}}, byte_sh[7:0]};
      2'b01:   load_data = {{16{sign_q & half_sh[15]}}, half_sh[15:0]};
      default: load_data = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Timeout cycle drops the request and releases the stall so EX/MEM advances.
  always_comb begin
    state_nxt    = state;
    stall_o      = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = {addr_q[31:2], 2'b00};
    dmem_be_o    = be_q;
    dmem_wdata_o = wdata_q;
    case (state)
      IDLE: begin
        stall_o = mem_op & ~misalign;
        if (mem_op && !misalign) state_nxt = BUS;
      end
      BUS: begin
        dmem_req_o = ~timeout;
        dmem_we_o  = ~timeout & we_q;
        stall_o    = ~timeout & ~dmem_ready_i;
        if (timeout || dmem_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      we_q           <= 1'b0;
      sign_q         <= 1'b0;
      regwr_q        <= 1'b0;
      size_q         <= '0;
      wreg_q         <= '0;
      cnt            <= '0;
      wb_valid_o     <= 1'b0;
      wb_reg_write_o <= 1'b0;
      wb_reg_addr_o  <= '0;
      wb_data_o      <= '0;
      exc_o          <= 1'b0;
      exc_code_o     <= '0;
      badaddr_o      <= '0;
    end else begin
      case (state)
        IDLE: begin
          wb_reg_addr_o <= wreg_addr_i;
          wb_data_o     <= addr_i;
          exc_o         <= 1'b0;
          exc_code_o    <= 2'b00;
          badaddr_o     <= '0;
          if (mem_op && !misalign) begin
            addr_q         <= addr_i;
            wdata_q        <= wdata_new;
            be_q           <= be_new;
            we_q           <= mem_wr_i;
            sign_q         <= mem_sign_i;
            regwr_q        <= reg_write_i;
            size_q         <= mem_size_i;
            wreg_q         <= wreg_addr_i;
            cnt            <= '0;
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
          end else if (mem_op) begin
            wb_valid_o     <= 1'b1;
            wb_reg_write_o <= 1'b0;
            exc_o          <= 1'b1;
            exc_code_o     <= mem_wr_i ? 2'b10 : 2'b01;
            badaddr_o      <= addr_i;
          end else begin
            wb_valid_o     <= valid_i;
            wb_reg_write_o <= reg_write_i;
          end
        end
        BUS: begin
          if (timeout) begin
            wb_valid_o     <= 1'b1;
            wb_reg_write_o <= 1'b0;
            wb_reg_addr_o  <= wreg_q;
            wb_data_o      <= addr_q;
            exc_o          <= 1'b1;
            exc_code_o     <= 2'b11;
            badaddr_o      <= addr_q;
          end else if (dmem_ready_i) begin
            wb_valid_o     <= 1'b1;
            wb_reg_write_o <= ~we_q & regwr_q;
            wb_reg_addr_o  <= wreg_q;
            wb_data_o      <= we_q ? addr_q : load_data;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// tb_mem_stage : directed self-checking bench for mem_stage (MAX_WAIT = 4).
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, mem_rd_i, mem_wr_i, mem_sign_i, reg_write_i;
  logic [1:0]  mem_size_i;
  logic [31:0] addr_i, wdata_i;
  logic [4:0]  wreg_addr_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ready_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o, wb_reg_write_o, exc_o;
  logic [4:0]  wb_reg_addr_o;
  logic [31:0] wb_data_o, badaddr_o;
  logic [1:0]  exc_code_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_rd_i(mem_rd_i),
    .mem_wr_i(mem_wr_i), .mem_size_i(mem_size_i), .mem_sign_i(mem_sign_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .wreg_addr_i(wreg_addr_i),
    .reg_write_i(reg_write_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ready_i(dmem_ready_i),
    .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o),
    .wb_reg_write_o(wb_reg_write_o), .wb_reg_addr_o(wb_reg_addr_o),
    .wb_data_o(wb_data_o), .exc_o(exc_o), .exc_code_o(exc_code_o),
    .badaddr_o(badaddr_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    valid_i = 0; mem_rd_i = 0; mem_wr_i = 0; mem_sign_i = 0; reg_write_i = 0;
    mem_size_i = 2'b00; addr_i = '0; wdata_i = '0; wreg_addr_i = '0;
    dmem_ready_i = 0; dmem_rdata_i = '0;
  endtask

  task automatic drive_mem(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                           input logic [4:0] rd_addr);
    valid_i = 1; mem_rd_i = rd; mem_wr_i = wr; mem_size_i = sz; mem_sign_i = sgn;
    addr_i = a; wdata_i = wd; wreg_addr_i = rd_addr; reg_write_i = rd;
  endtask

  initial begin
    rst = 1;
    clear_in();
    tick(); tick();
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_req", dmem_req_o, 0);
    check("rst_exc", exc_o, 0);
    check("rst_addr", dmem_addr_o, 0);
    check("rst_be", dmem_be_o, 0);
    rst = 0;

    // LB sign-extended from lane 3
    drive_mem(1, 0, 2'b00, 1, 32'h0000_1003, 0, 5'd5);
    #2;
    check("lb_stall_cap", stall_o, 1);
    check("lb_req_cap", dmem_req_o, 0);
    tick();
    dmem_ready_i = 1; dmem_rdata_i = 32'h80FF_0000;
    #2;
    check("lb_req_bus", dmem_req_o, 1);
    check("lb_stall_bus", stall_o, 0);
    check("lb_addr", dmem_addr_o, 32'h0000_1000);
    check("lb_we", dmem_we_o, 0);
    tick();
    clear_in();
    #2;
    check("lb_wb_valid", wb_valid_o, 1);
    check("lb_wb_data", wb_data_o, 32'hFFFF_FF80);
    check("lb_wb_rw", wb_reg_write_o, 1);
    check("lb_wb_ra", wb_reg_addr_o, 5);

    // SH to upper half
    drive_mem(0, 1, 2'b01, 0, 32'h0000_2002, 32'h0000_BEEF, 5'd6);
    reg_write_i = 1;
    #2;
    check("sh_stall_cap", stall_o, 1);
    tick();
    #2;
    check("sh_be", dmem_be_o, 4'b1100);
    check("sh_wdata", dmem_wdata_o, 32'hBEEF_BEEF);
    check("sh_we", dmem_we_o, 1);
    check("sh_addr", dmem_addr_o, 32'h0000_2000);
    dmem_ready_i = 1;
    tick();
    clear_in();
    #2;
    check("sh_wb_valid", wb_valid_o, 1);
    check("sh_wb_rw", wb_reg_write_o, 0);

    // LW, ready on third bus cycle, then back-to-back LHU
    drive_mem(1, 0, 2'b10, 0, 32'h0000_3008, 0, 5'd7);
    #2;
    check("lw_stall_cap", stall_o, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      #2;
      check("lw_req_wait", dmem_req_o, 1);
      check("lw_addr_wait", dmem_addr_o, 32'h0000_3008);
      check("lw_stall_wait", stall_o, 1);
      tick();
    end
    dmem_ready_i = 1; dmem_rdata_i = 32'hCAFE_F00D;
    #2;
    check("lw_req_done", dmem_req_o, 1);
    check("lw_stall_done", stall_o, 0);
    tick();
    clear_in();
    drive_mem(1, 0, 2'b01, 0, 32'h0000_300A, 0, 5'd8);
    #2;
    check("lw_wb_data", wb_data_o, 32'hCAFE_F00D);
    check("lw_wb_ra", wb_reg_addr_o, 7);
    check("lhu_stall_cap", stall_o, 1);
    check("lhu_req_cap", dmem_req_o, 0);
    tick();
    dmem_ready_i = 1; dmem_rdata_i = 32'h1234_5678;
    #2;
    check("lhu_req", dmem_req_o, 1);
    check("lhu_be", dmem_be_o, 4'b1100);
    tick();
    clear_in();
    #2;
    check("lhu_wb_data", wb_data_o, 32'h0000_1234);
    check("lhu_wb_rw", wb_reg_write_o, 1);

    // Bus timeout after 4 cycles
    drive_mem(1, 0, 2'b10, 0, 32'h4000_0010, 0, 5'd9);
    tick();
    for (int i = 0; i < 4; i++) begin
      #2;
      check("to_req_wait", dmem_req_o, 1);
      check("to_stall_wait", stall_o, 1);
      tick();
    end
    #2;
    check("to_req_drop", dmem_req_o, 0);
    check("to_stall_drop", stall_o, 0);
    tick();
    clear_in();
    #2;
    check("to_exc", exc_o, 1);
    check("to_code", exc_code_o, 2'b11);
    check("to_badaddr", badaddr_o, 32'h4000_0010);
    check("to_wb_rw", wb_reg_write_o, 0);
    check("to_wb_valid", wb_valid_o, 1);

    // Misaligned LW at 0x6
    drive_mem(1, 0, 2'b10, 0, 32'h0000_0006, 0, 5'd10);
`ifdef MEM_ALIGN_CHECK_EN
    #2;
    check("mis_stall", stall_o, 0);
    check("mis_req", dmem_req_o, 0);
    tick();
    clear_in();
    #2;
    check("mis_exc", exc_o, 1);
    check("mis_code", exc_code_o, 2'b01);
    check("mis_badaddr", badaddr_o, 32'h0000_0006);
    check("mis_wb_rw", wb_reg_write_o, 0);
    check("mis_wb_valid", wb_valid_o, 1);
`else
    #2;
    check("mis_stall", stall_o, 1);
    tick();
    dmem_ready_i = 1; dmem_rdata_i = 32'h1122_3344;
    #2;
    check("mis_req", dmem_req_o, 1);
    check("mis_addr", dmem_addr_o, 32'h0000_0004);
    tick();
    clear_in();
    #2;
    check("mis_wb_data", wb_data_o, 32'h1122_3344);
    check("mis_exc", exc_o, 0);
`endif

    // Reset during second bus cycle, then ALU pass-through
    drive_mem(0, 1, 2'b10, 0, 32'h0000_5000, 32'hA5A5_A5A5, 5'd0);
    tick();
    #2;
    check("rb_req1", dmem_req_o, 1);
    tick();
    rst = 1;
    #2;
    check("rb_req2", dmem_req_o, 1);
    tick();
    rst = 0;
    clear_in();
    #2;
    check("rb_req_after", dmem_req_o, 0);
    check("rb_we_after", dmem_we_o, 0);
    check("rb_stall_after", stall_o, 0);
    check("rb_wb_valid", wb_valid_o, 0);
    check("rb_addr_after", dmem_addr_o, 0);
    check("rb_be_after", dmem_be_o, 0);
    valid_i = 1; reg_write_i = 1; wreg_addr_i = 5'd3; addr_i = 32'hDEAD_0001;
    #2;
    check("alu_stall", stall_o, 0);
    check("alu_req", dmem_req_o, 0);
    tick();
    clear_in();
    #2;
    check("alu_wb_valid", wb_valid_o, 1);
    check("alu_wb_data", wb_data_o, 32'hDEAD_0001);
    check("alu_wb_rw", wb_reg_write_o, 1);
    check("alu_wb_ra", wb_reg_addr_o, 3);
    check("alu_exc", exc_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
